// File: rtl/press_detect_multi_pkg.sv
// Shared types for the multi-channel press detector.
// IDLE encodes as 0 so a cleared state register means IDLE.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } press_state_t;

  function automatic logic is_pressed(press_state_t s);
    return (s == HELD) || (s == RELEASING);
  endfunction

endpackage

// File: rtl/press_detect_multi_channel.sv
// One button channel: 2-flop synchronizer, tick-gated debounce FSM,
// registered level plus press/release/long one-shot pulses.
module press_channel
  import press_pkg::*;
#(
  parameter int CNT_W        = 10,
  parameter int DEBOUNCE_CNT = 6,
  parameter int LONG_CNT     = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic tick,
  input  logic btn_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             s1, s2;
  press_state_t     state, state_n;
  logic [CNT_W-1:0] dcnt, dcnt_n, lcnt, lcnt_n;
  logic             press_n, release_n, long_n;

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    lcnt_n    = lcnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      dcnt_n  = '0;
      lcnt_n  = '0;
    end else if (tick) begin
      case (state)
        IDLE: if (s2) begin
          state_n = ARMING;
          dcnt_n  = ONE;
        end
        ARMING: if (!s2) begin
          state_n = IDLE;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n = HELD;
          press_n = 1'b1;
          dcnt_n  = '0;
          lcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + ONE;
        end
        // lcnt saturates at L_MAX, so long fires once per press
        HELD: if (s2) begin
          if (lcnt != L_MAX) begin
            lcnt_n = lcnt + ONE;
            long_n = (lcnt_n == L_MAX);
          end
        end else begin
          state_n = RELEASING;
          dcnt_n  = ONE;
        end
        RELEASING: if (s2) begin
          state_n = HELD;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
          dcnt_n    = '0;
          lcnt_n    = '0;
        end else begin
          dcnt_n = dcnt + ONE;
        end
        default: begin
          state_n = IDLE;
          dcnt_n  = '0;
          lcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= IDLE;
      dcnt      <= '0;
      lcnt      <= '0;
      pressed_o <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
    end else begin
      s1        <= btn_i;
      s2        <= s1;
      state     <= state_n;
      dcnt      <= dcnt_n;
      lcnt      <= lcnt_n;
      pressed_o <= is_pressed(state_n);
      press_o   <= press_n;
      release_o <= release_n;
      long_o    <= long_n;
    end
  end

endmodule

// File: rtl/press_detect_multi.sv
// Multi-channel press detector: CHANNELS independent press_channel
// instances sharing enable and tick.
module press_detect_multi
  import press_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 10,
  parameter int DEBOUNCE_CNT = 6,
  parameter int LONG_CNT     = 500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                tick,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] pressed_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    press_channel #(
      .CNT_W       (CNT_W),
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .LONG_CNT    (LONG_CNT)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .tick     (tick),
      .btn_i    (btn_i[c]),
      .pressed_o(pressed_o[c]),
      .press_o  (press_o[c]),
      .release_o(release_o[c]),
      .long_o   (long_o[c])
    );
  end

endmodule
